// File: rtl/sme_share_regfile.sv
// Multi-share SME register file: NSHARE shares per entry with per-share write masks,
// optional write-to-read forwarding and a zeroisation sequencer that clears every entry.
module sme_share_regfile #(
  parameter int XLEN   = 32,
  parameter int NSHARE = 3,
  parameter int DEPTH  = 16,
  parameter int FWD    = 0,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                   g_clk,
  input  logic                   g_resetn,
  output logic                   g_clk_req,
  input  logic                   flush_req,
  output logic                   busy,
  input  logic [AW-1:0]          rs1_addr,
  output logic [NSHARE*XLEN-1:0] rs1_rdata,
  input  logic [AW-1:0]          rs2_addr,
  output logic [NSHARE*XLEN-1:0] rs2_rdata,
  input  logic                   rd_wen,
  input  logic [AW-1:0]          rd_addr,
  input  logic [NSHARE-1:0]      rd_wshare,
  input  logic [NSHARE*XLEN-1:0] rd_wdata
);

  localparam int DW = NSHARE * XLEN;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   ptr_q;
  logic            busy_q;
  logic [DW-1:0]   mem_q [DEPTH];
  logic [DW-1:0]   wmask;
  logic            hit1;
  logic            hit2;

  // Take new share bits where the mask is set, keep the old share elsewhere.
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                          input logic [DW-1:0] new_v,
                                          input logic [DW-1:0] m);
    merge = (new_v & m) | (old_v & ~m);
  endfunction

  always_comb begin
    wmask = '0;
    for (int i = 0; i < NSHARE; i++) begin
      wmask[i*XLEN +: XLEN] = {XLEN{rd_wshare[i]}};
    end
  end

  // Zeroisation sequencer; busy is registered so it is glitch-free for the caller.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          ptr_q <= ptr_q + AW'(1);
          if (ptr_q == AW'(DEPTH - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        IDLE: begin
          if (flush_req) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= CLEAR;
          ptr_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // Storage has no reset of its own; the sequencer owns the write port while busy.
  always_ff @(posedge g_clk) begin
    if (busy_q) begin
      mem_q[ptr_q] <= '0;
    end else if (rd_wen) begin
      mem_q[rd_addr] <= merge(mem_q[rd_addr], rd_wdata, wmask);
    end
  end

  assign hit1 = (FWD != 0) && rd_wen && !busy_q && (rs1_addr == rd_addr);
  assign hit2 = (FWD != 0) && rd_wen && !busy_q && (rs2_addr == rd_addr);

  always_comb begin
    rs1_rdata = '0;
    rs2_rdata = '0;
    if (!busy_q) begin
      rs1_rdata = hit1 ? merge(mem_q[rs1_addr], rd_wdata, wmask) : mem_q[rs1_addr];
      rs2_rdata = hit2 ? merge(mem_q[rs2_addr], rd_wdata, wmask) : mem_q[rs2_addr];
    end
  end

  assign busy      = busy_q;
  assign g_clk_req = rd_wen | busy_q | flush_req;

endmodule

// File: doc/sme_share_regfile.md
Name: sme_share_regfile

Overview:
Parametrised successor to the single-share SME register file. Each entry holds NSHARE shares of one masked value. Each share can be written independently through a per-share write mask. Write-to-read forwarding is optional. A built-in zeroisation sequencer clears all shares after reset or on request, so stale masked data never leaks. The block sits in the SME datapath and feeds share operands to the masked ALU.

Parameters:
XLEN, 32, width of one share in bits.
NSHARE, 3, shares per register entry; must be >= 2.
DEPTH, 16, number of entries; must be a power of two and >= 2.
FWD, 0, 1 = forward write data to read ports in the same cycle; 0 = no forwarding.
AW, $clog2(DEPTH), derived address width; do not override.

Ports:
g_clk  input  1  global clock.
g_resetn  input  1  reset, asynchronous, active-low.
g_clk_req  output  1  clock request = rd_wen | busy | flush_req.
flush_req  input  1  single-cycle pulse; starts zeroisation of all entries.
busy  output  1  high while zeroisation is in progress.
rs1_addr  input  AW  source 1 entry address.
rs1_rdata  output  NSHARE*XLEN  source 1 shares; share i occupies bits [i*XLEN +: XLEN].
rs2_addr  input  AW  source 2 entry address.
rs2_rdata  output  NSHARE*XLEN  source 2 shares; same packing as rs1_rdata.
rd_wen  input  1  write enable.
rd_addr  input  AW  write entry address.
rd_wshare  input  NSHARE  per-share write mask; bit i enables a write of share i.
rd_wdata  input  NSHARE*XLEN  write data; same packing as the read ports.

Behaviour:
- Clock/reset: one clock, g_clk. Reset g_resetn is asynchronous and active-low.
- Storage: DEPTH x NSHARE x XLEN flops. The storage array is NOT reset directly; the zeroise sequencer clears it.
- FSM states: CLEAR and IDLE. Pointer ptr is AW bits wide.
- Reset values: state = CLEAR, ptr = 0, busy = 1, g_clk_req = 1.
- CLEAR state:
  - Each rising edge writes all-zero to every share of entry ptr, then increments ptr.
  - When ptr == DEPTH-1 and that entry has been cleared, the next state is IDLE and ptr wraps to 0.
  - A full clear takes exactly DEPTH cycles; busy falls on the DEPTH-th edge after entry into CLEAR.
- IDLE state: flush_req = 1 causes a transition to CLEAR with ptr = 0 on the next edge.
- flush_req while in CLEAR: ignored; the sequence is not restarted.
- Reset asserted mid-clear: asynchronous return to CLEAR with ptr = 0; the sequence restarts from entry 0.
- Writes (IDLE only): on the rising edge with rd_wen = 1, share i of entry rd_addr takes rd_wdata share i if rd_wshare[i] = 1, otherwise keeps its old value. rd_wshare = 0 is a legal no-op.
- Writes while busy = 1: dropped silently; the caller must wait for busy = 0.
- Reads: combinational, zero cycles of latency.
  - While busy = 1, both rsX_rdata outputs are forced to all-zero, whatever the array contents.
- Forwarding, FWD = 1: if rd_wen = 1, busy = 0 and rsX_addr == rd_addr, then for each share i, rsX_rdata share i = rd_wdata share i when rd_wshare[i] = 1, otherwise the stored share.
- Forwarding, FWD = 0: reads return pre-write contents during the write cycle; new data is visible from the next cycle.
- Both read ports may address the same entry, and may address the entry being written; each port resolves independently.
- Widths: no arithmetic on data; addresses are exactly AW bits, so out-of-range addresses are impossible.

Test Plan:
1. Release reset (defaults) -> busy = 1 for exactly 16 cycles and rs1_rdata = 0 throughout; afterwards every entry reads 96'h0.
2. IDLE: write entry 5, rd_wshare = 3'b111, data {C,B,A}. Next cycle write entry 5, rd_wshare = 3'b101, data {F,E,D} -> entry 5 reads {F,B,D}.
3. FWD = 1: write entry 3 = {3,2,1} with mask 3'b111 and rs1_addr = 3 in the same cycle -> rs1_rdata = {3,2,1} in that cycle. With FWD = 0 the same stimulus returns the old value until the next cycle.
4. Fill all entries with nonzero data, pulse flush_req, and attempt a write on cycle 4 of the clear -> busy high for 16 cycles, the write is dropped, all entries then read 0, and g_clk_req stays high throughout.
5. Assert g_resetn low on cycle 7 of a clear, then release it -> the clear restarts at ptr = 0 and busy lasts a full 16 cycles after release.
6. Pulse flush_req again during CLEAR -> ignored; the total clear length remains 16 cycles.
